// File: rtl/jpeg_byte_stuffer_if.sv
// Stream interface for jpeg_byte_stuffer: packed-word input side, byte output side
// and the end-of-scan pulse. The slave modport is the stuffer's view.
interface jpeg_byte_stuffer_if;
    logic        data_in_valid;
    logic [31:0] data_in;
    logic        data_in_last;
    logic [2:0]  data_in_nbytes;
    logic        data_in_ready;
    logic        byte_out_valid;
    logic [7:0]  byte_out;
    logic        byte_out_ready;
    logic        frame_done;

    modport master (
        output data_in_valid,
        output data_in,
        output data_in_last,
        output data_in_nbytes,
        output byte_out_ready,
        input  data_in_ready,
        input  byte_out_valid,
        input  byte_out,
        input  frame_done
    );

    modport slave (
        input  data_in_valid,
        input  data_in,
        input  data_in_last,
        input  data_in_nbytes,
        input  byte_out_ready,
        output data_in_ready,
        output byte_out_valid,
        output byte_out,
        output frame_done
    );
endinterface

// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-stream byte stuffer: serialises 32-bit packed words LSB byte first and
// inserts 0x00 after every 0xFF. Define JPEG_EOI_MARKER_EN to append FF D9 after the last word.
module jpeg_byte_stuffer (
    input  logic                 clock,
    input  logic                 nreset,
    jpeg_byte_stuffer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EMIT   = 3'd1,
        STUFF  = 3'd2
`ifdef JPEG_EOI_MARKER_EN
        ,
        EOI_FF = 3'd3,
        EOI_D9 = 3'd4
`endif
    } state_t;

    function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Illegal counts are folded into the legal 1..4 range.
    function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
        logic [2:0] r;
        if (n == 3'd0) begin
            r = 3'd1;
        end else if (n > 3'd4) begin
            r = 3'd4;
        end else begin
            r = n;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic        last_q, last_d;
    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic [7:0]  byte_q, byte_d;
    logic        done_q, done_d;

    logic        byte_xfer_s;
    logic        last_byte_s;
    logic [7:0]  cur_byte_s;
    state_t      end_state_s;
    logic        end_done_s;

    assign byte_xfer_s = valid_q & bus.byte_out_ready;
    assign last_byte_s = ({1'b0, idx_q} == (nbytes_q - 3'd1));
    assign cur_byte_s  = sel_byte(word_q, idx_q);

    // Where the FSM goes once the final byte of the held word (and its stuff byte) is gone.
    always_comb begin
        end_state_s = IDLE;
        end_done_s  = 1'b0;
        if (last_q) begin
`ifdef JPEG_EOI_MARKER_EN
            end_state_s = EOI_FF;
            end_done_s  = 1'b0;
`else
            end_state_s = IDLE;
            end_done_s  = 1'b1;
`endif
        end else begin
            end_state_s = IDLE;
            end_done_s  = 1'b0;
        end
    end

    // Next-state logic for the serialiser FSM and the held word.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        word_d   = word_q;
        nbytes_d = nbytes_q;
        last_d   = last_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_in_valid && ready_q) begin
                    word_d   = bus.data_in;
                    nbytes_d = clamp_nbytes(bus.data_in_nbytes);
                    last_d   = bus.data_in_last;
                    idx_d    = 2'd0;
                    state_d  = EMIT;
                end else begin
                    state_d  = IDLE;
                end
            end
            EMIT: begin
                if (byte_xfer_s) begin
                    if (cur_byte_s == 8'hFF) begin
                        state_d = STUFF;
                    end else if (last_byte_s) begin
                        state_d = end_state_s;
                        done_d  = end_done_s;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                    end
                end else begin
                    state_d = EMIT;
                end
            end
            STUFF: begin
                if (byte_xfer_s) begin
                    if (last_byte_s) begin
                        state_d = end_state_s;
                        done_d  = end_done_s;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = EMIT;
                    end
                end else begin
                    state_d = STUFF;
                end
            end
`ifdef JPEG_EOI_MARKER_EN
            EOI_FF: begin
                if (byte_xfer_s) begin
                    state_d = EOI_D9;
                end else begin
                    state_d = EOI_FF;
                end
            end
            EOI_D9: begin
                if (byte_xfer_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = EOI_D9;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they leave the block registered;
    // a stalled byte keeps its state and therefore its value.
    always_comb begin
        byte_d  = 8'h00;
        valid_d = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        case (state_d)
            EMIT:    byte_d = sel_byte(word_d, idx_d);
            STUFF:   byte_d = 8'h00;
`ifdef JPEG_EOI_MARKER_EN
            EOI_FF:  byte_d = 8'hFF;
            EOI_D9:  byte_d = 8'hD9;
`endif
            default: byte_d = 8'h00;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            word_q   <= 32'h0000_0000;
            nbytes_q <= 3'd1;
            last_q   <= 1'b0;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            byte_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            nbytes_q <= nbytes_d;
            last_q   <= last_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            byte_q   <= byte_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_in_ready  = ready_q;
    assign bus.byte_out_valid = valid_q;
    assign bus.byte_out       = byte_q;
    assign bus.frame_done     = done_q;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Scoreboard bench for jpeg_byte_stuffer: expected bytes are queued when a word is
// handed over and compared as the DUT emits them; frame_done and stall stability are tracked.
module tb_jpeg_byte_stuffer;

    logic clock;
    logic nreset;

    jpeg_byte_stuffer_if bus();

    jpeg_byte_stuffer dut (
        .clock  (clock),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [7:0] b;
        logic       fin;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;     // 0: ready=1, 1: 0,0,1 per byte, 2: random, 3: one byte then stall
    int   pcnt  = 0;
    bit   oneshot = 1'b0;
    bit   done_exp = 1'b0;
    bit   held_v = 1'b0;
    logic [7:0] held_b = 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference byte sequence for one word.
    task automatic push_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
        int n;
        logic [7:0] b;
        n = (nb == 3'd0) ? 1 : ((nb > 3'd4) ? 4 : int'(nb));
        for (int i = 0; i < n; i++) begin
            b = w[8*i +: 8];
            q.push_back('{b: b, fin: 1'b0});
            if (b == 8'hFF) q.push_back('{b: 8'h00, fin: 1'b0});
        end
        if (last) begin
`ifdef JPEG_EOI_MARKER_EN
            q.push_back('{b: 8'hFF, fin: 1'b0});
            q.push_back('{b: 8'hD9, fin: 1'b1});
`else
            q[q.size()-1].fin = 1'b1;
`endif
        end
    endtask

    // Present a word; garbage is driven on the data fields while the DUT is not ready.
    task automatic send_word(input logic [31:0] w, input logic [2:0] nb, input logic last);
        bit ok = 1'b0;
        @(negedge clock);
        bus.data_in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (bus.data_in_ready) begin
                bus.data_in        = w;
                bus.data_in_nbytes = nb;
                bus.data_in_last   = last;
                push_word(w, nb, last);
                ok = 1'b1;
                break;
            end
            bus.data_in        = $urandom();
            bus.data_in_nbytes = 3'($urandom_range(0, 7));
            bus.data_in_last   = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        if (ok) @(posedge clock);
        else check_eq("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_in();
        @(negedge clock);
        bus.data_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clock);
            if (q.size() == 0 && !bus.byte_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("drain", 32'(ok), 32'd1);
        check_eq("ready_idle", 32'(bus.data_in_ready), 32'd1);
        @(negedge clock);
    endtask

    // Output side: drive byte_out_ready, then score the byte that will transfer at the next edge.
    always @(negedge clock) begin
        logic r;
        exp_t e;
        r = 1'b0;
        case (mode)
            0: r = 1'b1;
            1: begin
                if (bus.byte_out_valid) begin
                    if (pcnt == 2) begin r = 1'b1; pcnt = 0; end
                    else begin r = 1'b0; pcnt++; end
                end
            end
            2: r = 1'($urandom_range(0, 1));
            3: r = oneshot & bus.byte_out_valid;
            default: r = 1'b0;
        endcase
        bus.byte_out_ready = r;
        if (!nreset) begin
            held_v   = 1'b0;
            done_exp = 1'b0;
        end else begin
            check_eq("frame_done", 32'(bus.frame_done), 32'(done_exp));
            done_exp = 1'b0;
            if (held_v) begin
                check_eq("hold_valid", 32'(bus.byte_out_valid), 32'd1);
                check_eq("hold_byte", 32'(bus.byte_out), 32'(held_b));
            end
            if (bus.byte_out_valid && r) begin
                if (mode == 3) oneshot = 1'b0;
                if (q.size() == 0) begin
                    check_eq("extra_byte", 32'(bus.byte_out), 32'h100);
                end else begin
                    e = q.pop_front();
                    check_eq("byte", 32'(bus.byte_out), 32'(e.b));
                    done_exp = e.fin;
                end
            end
            held_v = bus.byte_out_valid && !r;
            held_b = bus.byte_out;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        nreset             = 1'b0;
        bus.data_in_valid  = 1'b0;
        bus.data_in        = 32'h0;
        bus.data_in_last   = 1'b0;
        bus.data_in_nbytes = 3'd4;
        repeat (3) @(negedge clock);
        check_eq("rst_valid", 32'(bus.byte_out_valid), 32'd0);
        check_eq("rst_byte", 32'(bus.byte_out), 32'h00);
        check_eq("rst_done", 32'(bus.frame_done), 32'd0);
        nreset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_rst", 32'(bus.data_in_ready), 32'd1);
        check_eq("idle_valid", 32'(bus.byte_out_valid), 32'd0);

        mode = 0;
        send_word(32'h44332211, 3'd4, 1'b0); idle_in(); wait_drain();
        send_word(32'h12FF34FF, 3'd4, 1'b0); idle_in(); wait_drain();
        send_word(32'h000000AB, 3'd1, 1'b1); idle_in(); wait_drain();

        mode = 1; pcnt = 0;
        send_word(32'hDDCCBBAA, 3'd4, 1'b0); idle_in(); wait_drain();

        mode = 0;
        send_word(32'hFFFF0102, 3'd4, 1'b0);
        send_word(32'h55667788, 3'd4, 1'b0);
        send_word(32'hA0B0FFC0, 3'd3, 1'b1);
        idle_in(); wait_drain();

        send_word(32'h99887766, 3'd0, 1'b1); idle_in(); wait_drain();
        send_word(32'hFF8877FF, 3'd7, 1'b1); idle_in(); wait_drain();

        mode = 2;
        for (int i = 0; i < 8; i++) begin
            w = $urandom();
            if (i % 3 == 0) w[15:8] = 8'hFF;
            if (i % 4 == 1) w[31:24] = 8'hFF;
            send_word(w, (i == 7) ? 3'd2 : 3'd4, (i == 7) ? 1'b1 : 1'b0);
        end
        idle_in(); wait_drain();

        // Reset while the stuff byte after 0xFF is pending.
        mode = 3; oneshot = 1'b1;
        send_word(32'h332211FF, 3'd4, 1'b0); idle_in();
        for (int k = 0; k < 50 && oneshot; k++) @(negedge clock);
        check_eq("oneshot_taken", 32'(oneshot), 32'd0);
        @(negedge clock);
        check_eq("stuff_valid", 32'(bus.byte_out_valid), 32'd1);
        check_eq("stuff_byte", 32'(bus.byte_out), 32'h00);
        nreset = 1'b0;
        #1;
        check_eq("async_valid", 32'(bus.byte_out_valid), 32'd0);
        check_eq("async_byte", 32'(bus.byte_out), 32'h00);
        q.delete();
        repeat (2) @(negedge clock);
        nreset = 1'b1;
        mode = 0;
        @(negedge clock);
        check_eq("ready_after_rst2", 32'(bus.data_in_ready), 32'd1);
        repeat (4) @(negedge clock);
        check_eq("no_out_after_rst", 32'(bus.byte_out_valid), 32'd0);
        send_word(32'h11223344, 3'd4, 1'b1); idle_in(); wait_drain();

        repeat (3) @(negedge clock);
        check_eq("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock for all state.
REQ-003 nreset  input  1  asynchronous active-low reset.
REQ-004 data_in_valid  input  1  upstream packed word present.
REQ-005 data_in  input  32  packed entropy-coded word; byte 0 = data_in[7:0], emitted first.
REQ-006 data_in_last  input  1  word is the final word of the scan.
REQ-007 data_in_nbytes  input  3  valid byte count of the word, 1..4; must be 4 unless data_in_last.
REQ-008 data_in_ready  output  1  block accepts a word this cycle.
REQ-009 byte_out_valid  output  1  byte_out holds a byte.
REQ-010 byte_out  output  8  output stream byte.
REQ-011 byte_out_ready  input  1  downstream accepts byte this cycle.
REQ-012 frame_done  output  1  one-cycle pulse when the final byte of a scan is accepted.

Function
REQ-013 A word SHALL transfer when data_in_valid and data_in_ready are both 1 on a rising clock edge; a byte SHALL transfer when byte_out_valid and byte_out_ready are both 1.
REQ-014 FSM states SHALL be IDLE, EMIT, STUFF, EOI_FF, EOI_D9; reset state IDLE.
REQ-015 data_in_ready SHALL be 1 only in IDLE; the block holds one word in an internal register.
REQ-016 On word transfer: latch data_in, data_in_nbytes, data_in_last, set byte index to 0, go to EMIT; byte_out_valid rises in the next cycle (1-cycle latency).
REQ-017 EMIT SHALL present byte[index] of the latched word; index 0..3 maps to bits [8i+7:8i].
REQ-018 On EMIT byte transfer with byte value 0xFF: go to STUFF; STUFF presents 0x00 and on transfer resumes at next index.
REQ-019 After the transfer of byte index nbytes-1 (and its stuff byte if any): if last=0 go to IDLE; if last=1 go to EOI_FF when JPEG_EOI_MARKER_EN is defined, else go to IDLE and pulse frame_done.
REQ-020 EOI_FF presents 0xFF (never stuffed); on transfer go to EOI_D9; EOI_D9 presents 0xD9; on transfer go to IDLE and pulse frame_done.
REQ-021 byte_out and byte_out_valid SHALL remain stable while byte_out_valid=1 and byte_out_ready=0 (no retraction, no value change).
REQ-022 In IDLE byte_out_valid SHALL be 0; byte_out is don't-care but driven to 0x00.
REQ-023 frame_done SHALL be registered, high for exactly the cycle after the final byte transfer.
REQ-024 data_in_nbytes of 0 or >4 is illegal; implementation SHALL treat 0 as 1 and >4 as 4.
REQ-025 data_in fields are sampled only at transfer; changes while data_in_ready=0 SHALL have no effect.

Reset
REQ-026 On nreset=0, asynchronously: state=IDLE, byte index=0, latched word=0, byte_out_valid=0, byte_out=0x00, frame_done=0, data_in_ready=1 from the first clock after release.
REQ-027 Reset asserted mid-word (including in STUFF or EOI states) SHALL discard the remaining bytes with no further output.

Configuration
REQ-028 Macro JPEG_EOI_MARKER_EN: defined -> after the last word, bytes 0xFF, 0xD9 are appended before frame_done; undefined -> EOI_FF/EOI_D9 are not compiled and frame_done follows the last data byte.

Verification
REQ-029 Word 0x44332211, nbytes=4, last=0, ready always 1 -> bytes 11,22,33,44 on consecutive cycles, then data_in_ready=1, no frame_done.
REQ-030 Word 0x12FF34FF, nbytes=4 -> bytes FF,00,34,FF,00,12 (6 transfers).
REQ-031 Word 0x000000AB, nbytes=1, last=1, macro defined -> AB,FF,D9 then frame_done pulse 1 cycle; macro undefined -> AB then frame_done.
REQ-032 Backpressure: byte_out_ready toggled 0,0,1 per byte on word 0xDDCCBBAA -> each byte held stable while stalled, order AA,BB,CC,DD, no drops or duplicates.
REQ-033 nreset pulsed low while in STUFF after byte FF -> byte_out_valid=0 immediately, no 0x00 emitted, next word accepted normally.
REQ-034 Back-to-back words with data_in_valid held 1 -> second word accepted only in IDLE; output stream is the exact concatenation.
